fetch_controller: RTL and testbench
===================================

Name: fetch_controller

Overview:
- Sequences the instruction memory: owns the PC and drives the fetch address.
- Latches the returned word into the IF/ID pipeline register with a valid bit.
- Handles decode stalls, branch/jump redirects with flush, and halting at end of program.
- Sits between the instruction memory (combinational, word-indexed by Address[11:2]) and the decode stage.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned).
IMEM_WORDS, 128, number of valid program words; END_PC = 4*IMEM_WORDS is the first out-of-program byte address.

Ports:
Clk  input  1  system clock, rising edge.
Reset_n  input  1  asynchronous, active-low reset.
Stall  input  1  decode stage cannot accept; hold PC and IF/ID contents.
Redirect  input  1  branch/jump taken; load RedirectTarget and flush.
RedirectTarget  input  32  new fetch byte address.
ImemAddress  output  32  address to instruction memory (= PC, bits [1:0] always 0).
ImemInstruction  input  32  word returned combinationally for ImemAddress.
IFID_Instruction  output  32  latched instruction to decode.
IFID_PCPlus4  output  32  PC+4 of the latched instruction.
IFID_Valid  output  1  IF/ID holds a real instruction (0 = bubble).
Halted  output  1  controller is in HALT.

Behaviour:
- Reset (Reset_n=0, async): state=BOOT, PC=RESET_PC, IFID_Instruction=0, IFID_PCPlus4=0, IFID_Valid=0, Halted=0.
- ImemAddress = {PC[31:2],2'b00}, combinational from the PC register. All other outputs are registered.
- States: BOOT, RUN, HALT.
- BOOT (one cycle):
  - next edge -> RUN; IF/ID unchanged (bubble); PC unchanged.
  - Redirect is ignored in BOOT.
- RUN, priority per edge is Redirect > Stall > end check > normal fetch:
  - Redirect=1: PC <= {RedirectTarget[31:2],2'b00}, IFID_Valid <= 0, IFID_Instruction <= 0. Applies even when Stall=1 (flush overrides hold).
  - Stall=1, Redirect=0: PC and all IF/ID outputs hold.
  - PC >= END_PC: state <= HALT, IFID_Valid <= 0, PC holds.
  - Otherwise: IFID_Instruction <= ImemInstruction, IFID_PCPlus4 <= PC+4, IFID_Valid <= 1, PC <= PC+4.
- Latency: an instruction at PC appears on IFID outputs one edge after PC is presented. The first valid instruction appears on the second rising edge after Reset_n deasserts.
- HALT:
  - Halted=1; IFID_Valid=0; PC holds; Stall ignored.
  - Redirect=1 with target < END_PC -> RUN, PC <= target.
  - Redirect=1 with target >= END_PC -> stay in HALT, PC <= target.
- Arithmetic: PC+4 is 32-bit modulo; wrap from 32'hFFFF_FFFC gives 0. The end check is an unsigned compare, so a wrapped PC still reaches HALT first.
- Misaligned RedirectTarget: low two bits are dropped silently.
- Reset asserted mid-stall or mid-redirect: async clear wins immediately, with no partial update.

Optional Feature:
- FETCH_PERF_EN defined: adds outputs FetchCount[31:0] and StallCount[31:0], both reset to 0.
  - FetchCount increments on every edge that sets IFID_Valid=1 via normal fetch.
  - StallCount increments on every RUN edge with Stall=1 and Redirect=0.
  - Both saturate at 32'hFFFF_FFFF.
- Not defined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package/header:
  - state encodings FETCH_BOOT=2'd0, FETCH_RUN=2'd1, FETCH_HALT=2'd2
  - NOP word 32'h0000_0000
  - INSTR_W=32
- Natural sub-module: ifid_register (32+32+1 bits with load, hold, flush), instantiated once. The PC/FSM logic stays in fetch_controller.

Test Plan:
- Reset release, memory[0]=32'h0000_4820, memory[1]=32'h2129_0006 -> edge1: Valid=0; edge2: IFID_Instruction=32'h0000_4820, PCPlus4=4, Valid=1; edge3: 32'h2129_0006, PCPlus4=8.
- Stall=1 for 3 cycles at PC=8 -> ImemAddress stays 8, IFID outputs frozen for 3 edges; fetch resumes at 8 after release.
- Redirect=1 with Stall=1, RedirectTarget=32'h0000_0043 at PC=12 -> next edge PC=0x40, Valid=0; following edge IFID_PCPlus4=0x44.
- Run with IMEM_WORDS=4 -> after word at 12 is latched, next edge Halted=1, Valid=0, PC=16 held; Redirect to 0 -> RUN, fetch restarts at 0.
- Reset_n pulsed low asynchronously between edges while Valid=1 -> outputs clear immediately; BOOT repeats.
- With FETCH_PERF_EN: 5 fetches, 2 stall cycles, 1 redirect -> FetchCount=5, StallCount=2.

Source files
------------

// File: rtl/fetch_controller_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_controller_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_BOOT = 2'd0,
        FETCH_RUN  = 2'd1,
        FETCH_HALT = 2'd2
    } fetch_state_t;

    // Force a byte address onto a word boundary by dropping the low two bits.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Bundles the instruction-memory and decode-side signals of the fetch stage.
// Latency: n/a (wiring only).
// Backpressure: Stall from decode holds the fetch stage; Redirect flushes it.
interface fetch_controller_if;
    import fetch_controller_pkg::*;

    logic               Stall;
    logic               Redirect;
    logic [31:0]        RedirectTarget;
    logic [31:0]        ImemAddress;
    logic [INSTR_W-1:0] ImemInstruction;
    logic [INSTR_W-1:0] IFID_Instruction;
    logic [31:0]        IFID_PCPlus4;
    logic               IFID_Valid;
    logic               Halted;

    // Fetch controller side.
    modport master (
        input  Stall, Redirect, RedirectTarget, ImemInstruction,
        output ImemAddress, IFID_Instruction, IFID_PCPlus4, IFID_Valid, Halted
    );

    // Memory/decode environment side.
    modport slave (
        output Stall, Redirect, RedirectTarget, ImemInstruction,
        input  ImemAddress, IFID_Instruction, IFID_PCPlus4, IFID_Valid, Halted
    );

endinterface

// File: rtl/fetch_controller_ifid_register.sv
// IF/ID pipeline register: instruction, PC+4 and a valid bit.
// Latency: one edge from load to outputs.
// Backpressure: holds when no control is asserted; flush beats kill beats load.
module fetch_controller_ifid_register
    import fetch_controller_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               flush,
    input  logic               kill,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [31:0]        pcp4_in,
    output logic [INSTR_W-1:0] instr,
    output logic [31:0]        pcp4,
    output logic               valid
);

    // flush drops the word (bubble with NOP), kill only invalidates, load captures.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr <= NOP_WORD;
            pcp4  <= 32'd0;
            valid <= 1'b0;
        end else if (flush) begin
            instr <= NOP_WORD;
            valid <= 1'b0;
        end else if (kill) begin
            valid <= 1'b0;
        end else if (load) begin
            instr <= instr_in;
            pcp4  <= pcp4_in;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// Owns the PC, drives the instruction memory and fills IF/ID; optional counters under FETCH_PERF_EN.
// Latency: word at PC appears on IF/ID one edge after PC is presented; first valid on 2nd edge after reset.
// Backpressure: Stall holds PC and IF/ID; Redirect overrides Stall and flushes; halts past end of program.
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 128
) (
    input  logic               Clk,
    input  logic               Reset_n,
    fetch_controller_if.master fif
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        FetchCount,
    output logic [31:0]        StallCount
`endif
);

    localparam logic [31:0] END_PC = 32'(IMEM_WORDS * 4);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         ifid_load, ifid_flush, ifid_kill;
    logic         fetch_evt, stall_evt;
    logic [31:0]  redirect_pc;

    assign redirect_pc     = word_align(fif.RedirectTarget);
    assign fif.ImemAddress = word_align(pc_q);
    assign fif.Halted      = (state_q == FETCH_HALT);

    // State and PC registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= FETCH_BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next state, next PC and IF/ID controls; Redirect > Stall > end check > fetch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        ifid_kill  = 1'b0;
        fetch_evt  = 1'b0;
        stall_evt  = 1'b0;
        case (state_q)
            FETCH_BOOT: begin
                state_d = FETCH_RUN;
            end
            FETCH_RUN: begin
                if (fif.Redirect) begin
                    pc_d       = redirect_pc;
                    ifid_flush = 1'b1;
                end else if (fif.Stall) begin
                    stall_evt = 1'b1;
                end else if (pc_q >= END_PC) begin
                    state_d   = FETCH_HALT;
                    ifid_kill = 1'b1;
                end else begin
                    pc_d      = pc_q + 32'd4;
                    ifid_load = 1'b1;
                    fetch_evt = 1'b1;
                end
            end
            FETCH_HALT: begin
                if (fif.Redirect) begin
                    pc_d = redirect_pc;
                    if (redirect_pc < END_PC) begin
                        state_d = FETCH_RUN;
                    end
                end
            end
            default: begin
                state_d = FETCH_BOOT;
            end
        endcase
    end

    fetch_controller_ifid_register u_ifid (
        .clk      (Clk),
        .rst_n    (Reset_n),
        .load     (ifid_load),
        .flush    (ifid_flush),
        .kill     (ifid_kill),
        .instr_in (fif.ImemInstruction),
        .pcp4_in  (pc_q + 32'd4),
        .instr    (fif.IFID_Instruction),
        .pcp4     (fif.IFID_PCPlus4),
        .valid    (fif.IFID_Valid)
    );

`ifdef FETCH_PERF_EN
    // Saturating fetch and stall event counters.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            FetchCount <= 32'd0;
            StallCount <= 32'd0;
        end else begin
            if (fetch_evt && (FetchCount != 32'hFFFF_FFFF)) begin
                FetchCount <= FetchCount + 32'd1;
            end
            if (stall_evt && (StallCount != 32'hFFFF_FFFF)) begin
                StallCount <= StallCount + 32'd1;
            end
        end
    end
`else
    logic unused_evt;
    assign unused_evt = fetch_evt ^ stall_evt;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Randomized bench for fetch_controller against a cycle-level reference of the fetch rules.
// Latency: checks every output 1 time unit after each rising edge.
// Backpressure: exercises Stall, Redirect (incl. with Stall), halt and async reset.
module tb_fetch_controller;
    import fetch_controller_pkg::*;

    localparam int          WORDS = 32;
    localparam logic [31:0] ENDA  = 32'(WORDS * 4);
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic Clk = 1'b0;
    logic Reset_n;
    always #5 Clk = ~Clk;

    fetch_controller_if fif ();

    logic [31:0] mem [0:1023];
    assign fif.ImemInstruction = mem[fif.ImemAddress[11:2]];

`ifdef FETCH_PERF_EN
    logic [31:0] FetchCount, StallCount;
`endif

    fetch_controller #(.RESET_PC(RPC), .IMEM_WORDS(WORDS)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .fif     (fif)
`ifdef FETCH_PERF_EN
        ,
        .FetchCount (FetchCount),
        .StallCount (StallCount)
`endif
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference: where the stage is, the PC, and what sits in IF/ID.
    bit          m_boot, m_halt, m_valid;
    logic [31:0] m_pc, m_instr, m_pcp4, m_fc, m_sc;

    task automatic model_reset();
        m_boot = 1; m_halt = 0; m_valid = 0;
        m_pc = RPC; m_instr = 0; m_pcp4 = 0; m_fc = 0; m_sc = 0;
    endtask

    task automatic model_edge(input bit stall, input bit redir, input logic [31:0] tgt);
        logic [31:0] t;
        t = {tgt[31:2], 2'b00};
        if (m_boot) begin
            m_boot = 0;
        end else if (m_halt) begin
            if (redir) begin
                m_pc = t;
                if (t < ENDA) m_halt = 0;
            end
        end else if (redir) begin
            m_pc = t; m_valid = 0; m_instr = 0;
        end else if (stall) begin
            if (m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
        end else if (m_pc >= ENDA) begin
            m_halt = 1; m_valid = 0;
        end else begin
            m_instr = mem[m_pc[11:2]];
            m_pcp4  = m_pc + 4;
            m_valid = 1;
            m_pc    = m_pc + 4;
            if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".addr"},  fif.ImemAddress,      m_pc);
        check({tag, ".instr"}, fif.IFID_Instruction, m_instr);
        check({tag, ".pcp4"},  fif.IFID_PCPlus4,     m_pcp4);
        check({tag, ".valid"}, 32'(fif.IFID_Valid),  32'(m_valid));
        check({tag, ".halt"},  32'(fif.Halted),      32'(m_halt));
`ifdef FETCH_PERF_EN
        check({tag, ".fcnt"},  FetchCount, m_fc);
        check({tag, ".scnt"},  StallCount, m_sc);
`endif
    endtask

    // Called 1 unit after a rising edge: apply inputs, take one edge, compare.
    task automatic cycle(input string tag, input bit stall, input bit redir, input logic [31:0] tgt);
        fif.Stall = stall; fif.Redirect = redir; fif.RedirectTarget = tgt;
        @(posedge Clk);
        model_edge(stall, redir, tgt);
        #1;
        check_all(tag);
    endtask

    // Async reset pulse placed between edges, then released before the next edge.
    task automatic pulse_reset(input string tag);
        #3 Reset_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        #2 Reset_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[0] = 32'h0000_4820;
        mem[1] = 32'h2129_0006;
        fif.Stall = 0; fif.Redirect = 0; fif.RedirectTarget = 0;
        Reset_n = 1'b0;
        #12;
        model_reset();
        check_all("rst");
        @(negedge Clk);
        #2 Reset_n = 1'b1;

        // Boot bubble, then first two words.
        cycle("boot", 0, 0, 0);
        check("e1.valid", 32'(fif.IFID_Valid), 32'd0);
        cycle("f0", 0, 0, 0);
        check("e2.instr", fif.IFID_Instruction, 32'h0000_4820);
        check("e2.pcp4", fif.IFID_PCPlus4, 32'd4);
        cycle("f1", 0, 0, 0);
        check("e3.instr", fif.IFID_Instruction, 32'h2129_0006);

        // Three stall cycles at PC=8, then resume.
        for (int i = 0; i < 3; i++) cycle("stall", 1, 0, 0);
        check("stall.addr", fif.ImemAddress, 32'd8);
        cycle("resume", 0, 0, 0);
        check("resume.pcp4", fif.IFID_PCPlus4, 32'd12);

        // Redirect beats stall; misaligned target.
        cycle("redir", 1, 1, 32'h0000_0043);
        check("redir.addr", fif.ImemAddress, 32'h40);
        cycle("redir2", 0, 0, 0);
        check("redir2.pcp4", fif.IFID_PCPlus4, 32'h44);

        // Run off the end of the program and halt.
        cycle("toend", 0, 1, ENDA - 8);
        for (int i = 0; i < 2; i++) cycle("tail", 0, 0, 0);
        cycle("halt", 0, 0, 0);
        check("halt.flag", 32'(fif.Halted), 32'd1);
        cycle("hstall", 1, 0, 0);
        cycle("hfar", 0, 1, ENDA + 32'h100);
        cycle("hback", 0, 1, 32'd0);
        cycle("refetch", 0, 0, 0);

        // Async reset with a valid word in IF/ID.
        pulse_reset("areset");
        cycle("boot2", 0, 0, 0);
        cycle("f0b", 0, 0, 0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            bit s, r;
            logic [31:0] t;
            s = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 9) == 0);
            t = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, WORDS * 4 + 24));
            if ($urandom_range(0, 99) == 0) pulse_reset("rnd.rst");
            cycle("rnd", s, r, t);
        end

        // Counter scenario: 5 fetches, 2 stalls, 1 redirect.
        pulse_reset("preset");
        cycle("pboot", 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle("pf", 0, 0, 0);
        cycle("ps", 1, 0, 0);
        cycle("ps", 1, 0, 0);
        cycle("pr", 0, 1, 32'h10);
        cycle("pf", 0, 0, 0);
        cycle("pf", 0, 0, 0);
`ifdef FETCH_PERF_EN
        check("perf.fetch", FetchCount, 32'd5);
        check("perf.stall", StallCount, 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
